front_pipe_regs: RTL and testbench
==================================

FRONT_PIPE_REGS -- requirements
Module: front_pipe_regs

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports stallF, stallD, flushD, flushE, input, 1 each, hazard-unit controls.
REQ-004 SHALL have ports pc_nextF, instrF, pc_plus4F, input, 32 each, fetch-stage PC mux output, imem data and PC+4.
REQ-005 SHALL have ports rs1D, rs2D, rdD, input, 5 each, decode register addresses.
REQ-006 SHALL have ports rd1D, rd2D, imm_extD, input, 32 each, decode operands.
REQ-007 SHALL have ports reg_writeD, mem_writeD, jumpD, branchD, alu_srcD, input, 1 each; result_srcD, input, 2; alu_controlD, input, 3.
REQ-008 SHALL have port pcF, output, 32, current fetch PC.
REQ-009 SHALL have ports instrD, pcD, pc_plus4D, output, 32 each, plus validD, output, 1.
REQ-010 SHALL have E-side outputs mirroring REQ-005..007 with suffix E (rs1E, rs2E, rdE, rd1E, rd2E, imm_extE, reg_writeE, result_srcE, mem_writeE, jumpE, branchE, alu_controlE, alu_srcE), plus pcE, pc_plus4E, 32, and validE, 1.
REQ-011 SHALL have ports stall_cnt, flush_cnt, output, 16 each, saturating event counters.

Function
REQ-012 SHALL update pcF <= pc_nextF each cycle when stallF=0 and hold pcF when stallF=1.
REQ-013 SHALL load the F->D register (instrD, pcD, pc_plus4D, validD=1) from fetch inputs when stallD=0 and flushD=0.
REQ-014 SHALL hold the F->D register when stallD=1 and flushD=0.
REQ-015 SHALL, when flushD=1, load instrD=NOP (32'h0000_0013), pcD=0, pc_plus4D=0, validD=0, irrespective of stallD (flush wins).
REQ-016 SHALL load the D->E register from all D inputs with validE=validD when flushE=0.
REQ-017 SHALL, when flushE=1, clear every E output to 0 (including rs1E, rs2E, rdE, all control bits, validE) to inject a bubble that cannot trigger forwarding or load-use stall.
REQ-018 SHALL have no stall input for D->E; it advances or clears every cycle.
REQ-019 SHALL give one-cycle latency per stage: a value presented at F appears on D outputs after one edge and on E outputs after two edges when unstalled/unflushed.
REQ-020 SHALL increment stall_cnt by 1 on each edge with stallF=1 or stallD=1, saturating at 16'hFFFF.
REQ-021 SHALL increment flush_cnt by 1 on each edge with flushD=1 or flushE=1, saturating at 16'hFFFF; one increment per cycle even if both assert.
REQ-022 SHALL treat stallF=1 with stallD=0 as legal (PC held, D still loads) and produce no X on any output.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set pcF=32'h0000_0000, instrD=NOP, validD=0, all other D and E outputs 0, both counters 0.
REQ-024 SHALL give reset priority over stall and flush inputs, including mid-stall or mid-flush.
REQ-025 SHALL leave the first fetch after reset release at pcF=0 with pcF advancing on the next unstalled edge.

Structure
REQ-026 SHALL take RESET_PC, NOP_INSTR, XLEN=32, and counter width 16 from the shared pipeline package.
REQ-027 SHALL instantiate a parameterised sub-module pipe_reg (WIDTH, CLR_VALUE; ports clk, reset, en, clr, d, q; clr over en) for the F->D and D->E registers.
REQ-028 SHALL contain no combinational path from any input to any output.

Verification
REQ-029 Bench SHALL reset then run 3 unstalled cycles with pc_nextF=0,4,8 -> pcF=0,4,8; instrD follows instrF one cycle later; validE=1 from cycle 3.
REQ-030 Bench SHALL assert stallF=stallD=1 and flushE=1 for one cycle (load-use) -> pcF and instrD hold, E outputs all 0, stall_cnt=1, flush_cnt=1.
REQ-031 Bench SHALL assert flushD=flushE=1 (taken branch) -> next cycle instrD=32'h0000_0013, validD=0, validE=0, rdE=0, reg_writeE=0, flush_cnt incremented by 1.
REQ-032 Bench SHALL assert stallD=1 and flushD=1 together -> instrD=NOP, validD=0 (flush wins).
REQ-033 Bench SHALL assert reset during stallF=1 with pcF=0x40 -> pcF=0, counters 0 next edge.
REQ-034 Bench SHALL hold stallF=1 for 65540 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/front_pipe_regs_pkg.sv
// Shared pipeline constants, stage-register bundles and the saturating counter helper
// used by the front-end pipeline registers.
package front_pipe_regs_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } fd_bus_t;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } de_bus_t;

  // A bubble in D must still look like a real NOP so decode logic sees no side effects.
  localparam fd_bus_t FD_CLR = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
  localparam de_bus_t DE_CLR = '0;

  function automatic cnt_t sat_inc(input cnt_t v, input logic ev);
    return (ev && (v != '1)) ? v + cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/front_pipe_regs_pipe_reg.sv
// Generic enable/clear pipeline register; clear beats enable, and reset loads the
// same value as clear.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VALUE;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= CLR_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/front_pipe_regs.sv
// Fetch PC register plus F->D and D->E pipeline registers with hazard-unit stall/flush
// controls and saturating stall/flush event counters.
module front_pipe_regs
  import front_pipe_regs_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            flushE,
  input  logic [XLEN-1:0] pc_nextF,
  input  logic [XLEN-1:0] instrF,
  input  logic [XLEN-1:0] pc_plus4F,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic [XLEN-1:0] rd1D,
  input  logic [XLEN-1:0] rd2D,
  input  logic [XLEN-1:0] imm_extD,
  input  logic            reg_writeD,
  input  logic            mem_writeD,
  input  logic            jumpD,
  input  logic            branchD,
  input  logic            alu_srcD,
  input  logic [1:0]      result_srcD,
  input  logic [2:0]      alu_controlD,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic [4:0]      rdE,
  output logic [XLEN-1:0] rd1E,
  output logic [XLEN-1:0] rd2E,
  output logic [XLEN-1:0] imm_extE,
  output logic            reg_writeE,
  output logic [1:0]      result_srcE,
  output logic            mem_writeE,
  output logic            jumpE,
  output logic            branchE,
  output logic [2:0]      alu_controlE,
  output logic            alu_srcE,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] pc_plus4E,
  output logic            validE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  cnt_t            stall_cnt_q;
  cnt_t            stall_cnt_d;
  cnt_t            flush_cnt_q;
  cnt_t            flush_cnt_d;
  fd_bus_t         fd_d;
  fd_bus_t         fd_q;
  de_bus_t         de_d;
  de_bus_t         de_q;

  always_comb begin
    pc_d        = stallF ? pc_q : pc_nextF;
    stall_cnt_d = sat_inc(stall_cnt_q, stallF | stallD);
    flush_cnt_d = sat_inc(flush_cnt_q, flushD | flushE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // F -> D boundary
  assign fd_d = '{instr: instrF, pc: pc_q, pc_plus4: pc_plus4F, valid: 1'b1};

  pipe_reg #(
    .WIDTH     ($bits(fd_bus_t)),
    .CLR_VALUE (FD_CLR)
  ) u_fd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stallD),
    .clr   (flushD),
    .d     (fd_d),
    .q     (fd_q)
  );

  // D -> E boundary: no stall, a flush zeroes register addresses too so the bubble
  // cannot match anything in the forwarding or load-use comparators.
  assign de_d = '{rs1: rs1D, rs2: rs2D, rd: rdD, rd1: rd1D, rd2: rd2D, imm_ext: imm_extD,
                  reg_write: reg_writeD, result_src: result_srcD, mem_write: mem_writeD,
                  jump: jumpD, branch: branchD, alu_control: alu_controlD, alu_src: alu_srcD,
                  pc: fd_q.pc, pc_plus4: fd_q.pc_plus4, valid: fd_q.valid};

  pipe_reg #(
    .WIDTH     ($bits(de_bus_t)),
    .CLR_VALUE (DE_CLR)
  ) u_de_reg (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (flushE),
    .d     (de_d),
    .q     (de_q)
  );

  assign pcF          = pc_q;
  assign instrD       = fd_q.instr;
  assign pcD          = fd_q.pc;
  assign pc_plus4D    = fd_q.pc_plus4;
  assign validD       = fd_q.valid;
  assign rs1E         = de_q.rs1;
  assign rs2E         = de_q.rs2;
  assign rdE          = de_q.rd;
  assign rd1E         = de_q.rd1;
  assign rd2E         = de_q.rd2;
  assign imm_extE     = de_q.imm_ext;
  assign reg_writeE   = de_q.reg_write;
  assign result_srcE  = de_q.result_src;
  assign mem_writeE   = de_q.mem_write;
  assign jumpE        = de_q.jump;
  assign branchE      = de_q.branch;
  assign alu_controlE = de_q.alu_control;
  assign alu_srcE     = de_q.alu_src;
  assign pcE          = de_q.pc;
  assign pc_plus4E    = de_q.pc_plus4;
  assign validE       = de_q.valid;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_front_pipe_regs.sv
// Directed bench for front_pipe_regs: a cycle-level reference model checked against
// every output on each falling edge, plus hand-computed literal expectations.
module tb_front_pipe_regs;

  logic        clk = 1'b0;
  logic        reset, stallF, stallD, flushD, flushE;
  logic [31:0] pc_nextF, instrF, pc_plus4F;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [31:0] rd1D, rd2D, imm_extD;
  logic        reg_writeD, mem_writeD, jumpD, branchD, alu_srcD;
  logic [1:0]  result_srcD;
  logic [2:0]  alu_controlD;

  logic [31:0] pcF, instrD, pcD, pc_plus4D;
  logic        validD;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [31:0] rd1E, rd2E, imm_extE, pcE, pc_plus4E;
  logic        reg_writeE, mem_writeE, jumpE, branchE, alu_srcE, validE;
  logic [1:0]  result_srcE;
  logic [2:0]  alu_controlE;
  logic [15:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  front_pipe_regs dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .pc_nextF(pc_nextF), .instrF(instrF), .pc_plus4F(pc_plus4F),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .rd1D(rd1D), .rd2D(rd2D), .imm_extD(imm_extD),
    .reg_writeD(reg_writeD), .mem_writeD(mem_writeD), .jumpD(jumpD), .branchD(branchD),
    .alu_srcD(alu_srcD), .result_srcD(result_srcD), .alu_controlD(alu_controlD),
    .pcF(pcF), .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rd1E(rd1E), .rd2E(rd2E), .imm_extE(imm_extE),
    .reg_writeE(reg_writeE), .result_srcE(result_srcE), .mem_writeE(mem_writeE),
    .jumpE(jumpE), .branchE(branchE), .alu_controlE(alu_controlE), .alu_srcE(alu_srcE),
    .pcE(pcE), .pc_plus4E(pc_plus4E), .validE(validE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: what each architectural register must hold after an edge.
  logic [31:0]  m_pcF, m_instrD, m_pcD, m_pp4D;
  logic         m_validD;
  logic [185:0] m_E;
  logic [15:0]  m_stall, m_flush;

  always @(posedge clk) begin
    if (reset) begin
      m_pcF = 32'h0; m_instrD = 32'h0000_0013; m_pcD = 32'h0; m_pp4D = 32'h0;
      m_validD = 1'b0; m_E = '0; m_stall = 16'h0; m_flush = 16'h0;
    end else begin
      if (flushE) m_E = '0;
      else m_E = {rs1D, rs2D, rdD, rd1D, rd2D, imm_extD, reg_writeD, result_srcD, mem_writeD,
                  jumpD, branchD, alu_controlD, alu_srcD, m_pcD, m_pp4D, m_validD};
      if (flushD) begin
        m_instrD = 32'h0000_0013; m_pcD = 32'h0; m_pp4D = 32'h0; m_validD = 1'b0;
      end else if (!stallD) begin
        m_instrD = instrF; m_pcD = m_pcF; m_pp4D = pc_plus4F; m_validD = 1'b1;
      end
      if (!stallF) m_pcF = pc_nextF;
      if ((stallF || stallD) && m_stall < 16'hFFFF) m_stall = m_stall + 16'd1;
      if ((flushD || flushE) && m_flush < 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  end

  wire [346:0] dut_vec = {pcF, instrD, pcD, pc_plus4D, validD, rs1E, rs2E, rdE, rd1E, rd2E,
                          imm_extE, reg_writeE, result_srcE, mem_writeE, jumpE, branchE,
                          alu_controlE, alu_srcE, pcE, pc_plus4E, validE, stall_cnt, flush_cnt};
  wire [346:0] exp_vec = {m_pcF, m_instrD, m_pcD, m_pp4D, m_validD, m_E, m_stall, m_flush};

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: dut=%h model=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] nxt, input logic [31:0] ins, input logic [31:0] p4);
    pc_nextF = nxt; instrF = ins; pc_plus4F = p4;
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    fetch(32'h0, 32'h0, 32'h0);
    rs1D = 5'd1; rs2D = 5'd2; rdD = 5'd5;
    rd1D = 32'hAAAA_0001; rd2D = 32'hBBBB_0002; imm_extD = 32'h0000_0010;
    reg_writeD = 1'b1; mem_writeD = 1'b0; jumpD = 1'b0; branchD = 1'b1; alu_srcD = 1'b1;
    result_srcD = 2'b01; alu_controlD = 3'b010;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_pcF", pcF, 32'h0);
    chk("rst_instrD", instrD, 32'h0000_0013);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_validE", {31'b0, validE}, 32'h0);
    chk("rst_rdE", {27'b0, rdE}, 32'h0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);

    reset = 1'b0;
    fetch(32'h0, 32'h0050_0093, 32'h4); cyc();
    chk("run0_pcF", pcF, 32'h0);
    chk("run0_instrD", instrD, 32'h0050_0093);
    chk("run0_validD", {31'b0, validD}, 32'h1);
    fetch(32'h4, 32'h0010_8113, 32'h4); cyc();
    chk("run1_pcF", pcF, 32'h4);
    chk("run1_instrD", instrD, 32'h0010_8113);
    fetch(32'h8, 32'h0020_0193, 32'h8); cyc();
    chk("run2_pcF", pcF, 32'h8);
    chk("run2_instrD", instrD, 32'h0020_0193);
    chk("run2_pcD", pcD, 32'h4);
    chk("run2_validE", {31'b0, validE}, 32'h1);
    chk("run2_rdE", {27'b0, rdE}, 32'h5);
    chk("run2_pcE", pcE, 32'h0);

    stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
    fetch(32'hC, 32'h0030_0213, 32'hC); cyc();
    chk("lu_pcF", pcF, 32'h8);
    chk("lu_instrD", instrD, 32'h0020_0193);
    chk("lu_validE", {31'b0, validE}, 32'h0);
    chk("lu_rdE", {27'b0, rdE}, 32'h0);
    chk("lu_rd1E", rd1E, 32'h0);
    chk("lu_regwE", {31'b0, reg_writeE}, 32'h0);
    chk("lu_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});

    stallF = 1'b0; stallD = 1'b0; flushD = 1'b1; flushE = 1'b1;
    fetch(32'h20, 32'h0030_0213, 32'hC); cyc();
    chk("br_instrD", instrD, 32'h0000_0013);
    chk("br_validD", {31'b0, validD}, 32'h0);
    chk("br_validE", {31'b0, validE}, 32'h0);
    chk("br_rdE", {27'b0, rdE}, 32'h0);
    chk("br_regwE", {31'b0, reg_writeE}, 32'h0);
    chk("br_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd2});
    chk("br_pcF", pcF, 32'h20);

    flushD = 1'b0; flushE = 1'b0;
    fetch(32'h24, 32'h0040_0293, 32'h24); cyc();
    chk("nrm_instrD", instrD, 32'h0040_0293);

    stallD = 1'b1; flushD = 1'b1;
    fetch(32'h28, 32'h0050_0313, 32'h28); cyc();
    chk("sfw_instrD", instrD, 32'h0000_0013);
    chk("sfw_validD", {31'b0, validD}, 32'h0);
    chk("sfw_cnts", {stall_cnt, flush_cnt}, {16'd2, 16'd3});

    stallD = 1'b0; flushD = 1'b0; stallF = 1'b1;
    fetch(32'h2C, 32'h0060_0393, 32'h2C); cyc();
    chk("sfo_pcF", pcF, 32'h28);
    chk("sfo_instrD", instrD, 32'h0060_0393);
    chk("sfo_pcD", pcD, 32'h28);

    stallF = 1'b0; fetch(32'h40, 32'h0, 32'h40); cyc();
    chk("pre_rst_pcF", pcF, 32'h40);
    stallF = 1'b1; fetch(32'h44, 32'h0, 32'h44); cyc();
    chk("pre_rst_hold", pcF, 32'h40);
    reset = 1'b1; flushD = 1'b1; cyc();
    chk("midrst_pcF", pcF, 32'h0);
    chk("midrst_cnts", {stall_cnt, flush_cnt}, 32'h0);
    chk("midrst_instrD", instrD, 32'h0000_0013);

    reset = 1'b0; flushD = 1'b0; flushE = 1'b1;
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat_stall", {16'h0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_flush", {16'h0, flush_cnt}, 32'h0000_FFFF);
    chk("sat_pcF", pcF, 32'h0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
